gmii_rx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 18 +
 rtl/gmii_rx_framer_if.sv | 24 ++
 rtl/crc32_d8.sv | 20 ++
 rtl/gmii_rx_framer.sv | 179 +++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the framer FSM state type.
// The CRC constants are also used by the transmit FCS generator.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          LINE_DEPTH    = 5;
  localparam int          LEN_W         = 11;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;
endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive byte stream in, payload stream with per-frame status out.
// The framer uses master; the stream source/consumer side uses slave.
interface gmii_rx_framer_if;
  import eth_pkg::*;

  logic [7:0]       gmii_rxd;
  logic             gmii_rx_dv;
  logic             gmii_rx_er;
  logic [7:0]       m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tuser;
  logic [LEN_W-1:0] frame_len;

  modport master (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output m_tdata, m_tvalid, m_tlast, m_tuser, frame_len
  );

  modport slave (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  m_tdata, m_tvalid, m_tlast, m_tuser, frame_len
  );
endinterface

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Data bits are consumed LSB first, as they appear on the wire.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? CRC32_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks and removes the FCS,
// and delivers payload bytes with per-frame length/status and statistics.
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64,
  parameter int CNT_W     = 32
) (
  input  logic             rx_clk,
  input  logic             rx_reset_n,
  gmii_rx_framer_if.master rx,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames,
  output logic [CNT_W-1:0] dropped_frames
);

  rx_state_e        state_q, state_d;
  logic [4:0][7:0]  line_q;
  logic [2:0]       fill_q;
  logic [LEN_W-1:0] len_q, len_inc;
  logic [31:0]      crc_q, crc_nxt;
  logic             er_q;
  logic             silent_drop_q;

  logic             line_full, frame_bad;
  logic             clear_frame, shift;
  logic             emit, emit_last, emit_bad;
  logic [LEN_W-1:0] emit_len;
  logic             cnt_good, cnt_bad, cnt_drop, enter_silent;

  crc32_d8 u_crc (
    .data    (rx.gmii_rxd),
    .crc_in  (crc_q),
    .crc_out (crc_nxt)
  );

  assign line_full = (fill_q == 3'(LINE_DEPTH));
  assign len_inc   = (len_q == '1) ? len_q : len_q + 11'd1;
  assign frame_bad = (crc_q != CRC32_RESIDUE) || er_q || (len_q < LEN_W'(MIN_FRAME));

  always_ff @(posedge rx_clk) begin
    if (!rx_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_frame  = 1'b0;
    shift        = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_bad     = 1'b0;
    emit_len     = '0;
    cnt_good     = 1'b0;
    cnt_bad      = 1'b0;
    cnt_drop     = 1'b0;
    enter_silent = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx.gmii_rx_dv) begin
          if (rx.gmii_rxd == ETH_PREAMBLE) begin
            state_d = PRE;
          end else if (rx.gmii_rxd == ETH_SFD) begin
            state_d     = DATA;
            clear_frame = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!rx.gmii_rx_dv) begin
          state_d  = IDLE;
          cnt_drop = 1'b1;
        end else if (rx.gmii_rxd == ETH_SFD) begin
          state_d     = DATA;
          clear_frame = 1'b1;
        end else if (rx.gmii_rxd != ETH_PREAMBLE) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx.gmii_rx_dv) begin
          shift = 1'b1;
          emit  = line_full;
          // Oversize: cut the frame here and discard the rest of the burst.
          if (len_q == LEN_W'(MAX_FRAME)) begin
            emit_last    = 1'b1;
            emit_bad     = 1'b1;
            emit_len     = LEN_W'(MAX_FRAME + 1);
            cnt_bad      = 1'b1;
            enter_silent = 1'b1;
            state_d      = DROP;
          end
        end else begin
          state_d = IDLE;
          if (!line_full) begin
            cnt_drop = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_bad  = frame_bad;
            emit_len  = len_q;
            cnt_good  = !frame_bad;
            cnt_bad   = frame_bad;
          end
        end
      end
      DROP: begin
        if (!rx.gmii_rx_dv) begin
          state_d  = IDLE;
          cnt_drop = !silent_drop_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: delay line, CRC and length accumulate after the SFD.
  always_ff @(posedge rx_clk) begin
    if (shift) begin
      line_q <= {line_q[3:0], rx.gmii_rxd};
    end
    if (clear_frame) begin
      crc_q <= CRC32_INIT;
      len_q <= '0;
    end else if (shift) begin
      crc_q <= crc_nxt;
      len_q <= len_inc;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_reset_n) begin
      fill_q        <= '0;
      er_q          <= 1'b0;
      silent_drop_q <= 1'b0;
    end else begin
      if (clear_frame) begin
        fill_q <= '0;
        er_q   <= 1'b0;
      end else if (shift) begin
        if (!line_full) fill_q <= fill_q + 3'd1;
        er_q <= er_q | rx.gmii_rx_er;
      end
      if (state_d == DROP && state_q != DROP) begin
        silent_drop_q <= enter_silent;
      end
    end
  end

  // Output register stage and statistics.
  always_ff @(posedge rx_clk) begin
    if (!rx_reset_n) begin
      rx.m_tdata     <= '0;
      rx.m_tvalid    <= 1'b0;
      rx.m_tlast     <= 1'b0;
      rx.m_tuser     <= 1'b0;
      rx.frame_len   <= '0;
      good_frames    <= '0;
      bad_frames     <= '0;
      dropped_frames <= '0;
    end else begin
      rx.m_tvalid  <= emit;
      rx.m_tlast   <= emit_last;
      rx.m_tuser   <= emit_bad;
      rx.frame_len <= emit_len;
      if (emit) rx.m_tdata <= line_q[4];
      if (cnt_good) good_frames    <= good_frames + CNT_W'(1);
      if (cnt_bad)  bad_frames     <= bad_frames + CNT_W'(1);
      if (cnt_drop) dropped_frames <= dropped_frames + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed plus randomized frames checked against a frame-level reference
// model that works from whole byte lists and the Ethernet FCS definition.
module tb_gmii_rx_framer;
  import eth_pkg::*;

  localparam int MAX_FRAME = 1518;
  localparam int MIN_FRAME = 64;
  localparam int CNT_W     = 32;

  logic             rx_clk = 1'b0;
  logic             rx_reset_n = 1'b0;
  logic [CNT_W-1:0] good_frames, bad_frames, dropped_frames;

  gmii_rx_framer_if bus ();

  gmii_rx_framer #(
    .MAX_FRAME (MAX_FRAME),
    .MIN_FRAME (MIN_FRAME),
    .CNT_W     (CNT_W)
  ) dut (
    .rx_clk         (rx_clk),
    .rx_reset_n     (rx_reset_n),
    .rx             (bus),
    .good_frames    (good_frames),
    .bad_frames     (bad_frames),
    .dropped_frames (dropped_frames)
  );

  always #4 rx_clk = ~rx_clk;

  int               n_asserts = 0;
  int               n_fails   = 0;
  logic [7:0]       frame [$];
  logic [20:0]      got_q [$];
  logic [20:0]      exp_q [$];
  logic [CNT_W-1:0] exp_good = '0, exp_bad = '0, exp_drop = '0;

  // Beat record: {tlast, tuser, frame_len, tdata}; status only kept on tlast.
  always @(negedge rx_clk) begin
    if (bus.m_tvalid) begin
      got_q.push_back({bus.m_tlast, bus.m_tlast ? bus.m_tuser : 1'b0,
                       bus.m_tlast ? bus.frame_len : 11'd0, bus.m_tdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frame[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int payload_len);
    logic [31:0] f;
    frame.delete();
    for (int i = 0; i < payload_len; i++) frame.push_back(8'($urandom));
    f = eth_fcs(payload_len);
    for (int i = 0; i < 4; i++) frame.push_back(f[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge rx_clk);
    #1;
    bus.gmii_rx_dv = dv;
    bus.gmii_rx_er = er;
    bus.gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 8'($urandom));
  endtask

  // Reference: what a whole received frame (bytes after the SFD) must produce.
  task automatic model(input bit er_seen);
    int n = frame.size();
    bit bad;
    if (n < LINE_DEPTH) begin
      exp_drop++;
    end else if (n > MAX_FRAME) begin
      for (int i = 0; i <= MAX_FRAME - 5; i++)
        exp_q.push_back({(i == MAX_FRAME - 5), (i == MAX_FRAME - 5),
                         (i == MAX_FRAME - 5) ? 11'(MAX_FRAME + 1) : 11'd0, frame[i]});
      exp_bad++;
    end else begin
      bad = er_seen || (n < MIN_FRAME) ||
            (eth_fcs(n - 4) != {frame[n-1], frame[n-2], frame[n-3], frame[n-4]});
      for (int i = 0; i <= n - 5; i++)
        exp_q.push_back({(i == n - 5), (i == n - 5) && bad,
                         (i == n - 5) ? 11'(n) : 11'd0, frame[i]});
      if (bad) exp_bad++;
      else     exp_good++;
    end
  endtask

  task automatic send(input int pre, input int er_idx);
    repeat (pre) drive(1'b1, 1'b0, ETH_PREAMBLE);
    drive(1'b1, 1'b0, ETH_SFD);
    for (int i = 0; i < frame.size(); i++) drive(1'b1, (i == er_idx), frame[i]);
    model(er_idx >= 0 && er_idx < frame.size());
  endtask

  task automatic drain(input string tag);
    int m;
    idle(10);
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_good"}, good_frames, exp_good);
    check({tag, "_bad"}, bad_frames, exp_bad);
    check({tag, "_drop"}, dropped_frames, exp_drop);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int plen, er_idx;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (4) @(posedge rx_clk);
    #1;
    check("rst_tvalid", bus.m_tvalid, 0);
    check("rst_tlast", bus.m_tlast, 0);
    check("rst_tuser", bus.m_tuser, 0);
    check("rst_tdata", bus.m_tdata, 0);
    check("rst_len", bus.frame_len, 0);
    check("rst_good", good_frames, 0);
    check("rst_bad", bad_frames, 0);
    check("rst_drop", dropped_frames, 0);
    rx_reset_n = 1'b1;
    idle(3);

    build(60);                      send(7, -1); drain("good64");
    frame[10] ^= 8'h04;             send(7, -1); drain("bitflip");
    build(60);                      send(7, 20); drain("rx_er");
    build(36);                      send(7, -1); drain("runt40");
    build(1596);                    send(7, -1); drain("oversize");

    drive(1'b1, 1'b0, 8'h33);
    repeat (10) drive(1'b1, 1'b0, 8'($urandom));
    exp_drop++;                                  drain("bad_start");
    repeat (6) drive(1'b1, 1'b0, ETH_PREAMBLE);
    exp_drop++;                                  drain("pre_only");
    repeat (3) drive(1'b1, 1'b0, ETH_PREAMBLE);
    repeat (4) drive(1'b1, 1'b0, 8'h12);
    exp_drop++;                                  drain("pre_garbage");

    build(60);  send(7, -1); idle(1);
    build(80);  send(7, -1); drain("back2back");
    build(100); send(0, -1); drain("no_preamble");
    frame.delete();
    for (int i = 0; i < 3; i++) frame.push_back(8'($urandom));
    send(7, -1);                                 drain("short3");

    for (int t = 0; t < 25; t++) begin
      plen = $urandom_range(0, 116);
      build(plen);
      if ($urandom_range(0, 3) == 0) frame[$urandom_range(0, frame.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      er_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, frame.size() - 1) : -1;
      send($urandom_range(0, 7), er_idx);
      idle($urandom_range(1, 3));
    end
    drain("random");

    build(60);
    repeat (7) drive(1'b1, 1'b0, ETH_PREAMBLE);
    drive(1'b1, 1'b0, ETH_SFD);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, frame[i]);
    rx_reset_n = 1'b0;
    idle(2);
    rx_reset_n = 1'b1;
    exp_good = '0; exp_bad = '0; exp_drop = '0;
    drain("mid_reset");
    build(70); send(2, -1); drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
